sar_channel_sequencer: RTL and testbench
========================================

// Module: sar_channel_sequencer
// PURPOSE
//  Round-robin scheduler that shares one analog comparator and one 8-bit DAC among NCH sensor channels.
//  Runs a successive-approximation conversion per enabled channel and stores each result in a per-channel register.
//  Results feed the threshold/hysteresis controllers downstream.
//  Sits between the analog front end (mux select, DAC code, comparator bit) and the per-channel control logic.
// PARAMETERS
//  NCH     4  number of sensor channels (2..8)
//  WIDTH   8  conversion width in bits; DAC code width
//  SETTLE  2  cycles a trial DAC code is held before the comparator is sampled (>=1)
// PORTS
//  clk           in   1              system clock, rising edge
//  rst           in   1              asynchronous reset, active-low
//  en            in   1              1 = keep scanning; 0 = stop after the current conversion
//  ch_mask       in   NCH            bit i = 1 includes channel i in the scan
//  comp_in       in   1              comparator: 1 when the selected channel input is >= dac_code
//  ch_sel        out  $clog2(NCH)    analog mux select, held for the whole conversion
//  dac_code      out  WIDTH          trial code driven to the DAC
//  busy          out  1              1 in any state other than IDLE
//  result        out  WIDTH          final code of the last completed conversion
//  result_ch     out  $clog2(NCH)    channel that produced result
//  result_valid  out  1              1-cycle pulse when result/result_ch update
//  rd_ch         in   $clog2(NCH)    combinational read select for stored results
//  rd_data       out  WIDTH          stored result of channel rd_ch (0 until the channel has been converted)
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE; ch_sel, dac_code, result, result_ch, result_valid, busy, all stored results = 0.
//   - last_ch=NCH-1, so the first pick is the lowest enabled channel >= 0.
//   - Reset mid-conversion aborts it; no result_valid is produced.
//  FSM states: IDLE, PICK, SETTLE, COMPARE, DONE.
//   - IDLE: if en && |ch_mask -> PICK, else stay. dac_code=0.
//   - PICK (1 cycle):
//       ch_sel = first channel with mask bit set, searching last_ch+1, last_ch+2, ... with wrap modulo NCH.
//       If ch_mask == last_ch only, last_ch is reselected.
//       bit_idx=WIDTH-1; dac_code = 1<<(WIDTH-1); settle counter loaded with SETTLE-1. -> SETTLE.
//       If |ch_mask==0 at PICK -> IDLE.
//   - SETTLE: count down; at 0 -> COMPARE. Duration is SETTLE cycles.
//   - COMPARE (1 cycle, comp_in sampled at the clock edge leaving it):
//       if comp_in=0, clear dac_code[bit_idx].
//       If bit_idx>0: set dac_code[bit_idx-1], bit_idx--, reload counter -> SETTLE.
//       If bit_idx==0 -> DONE.
//   - DONE (1 cycle):
//       result=dac_code, result_ch=ch_sel, result_valid=1, store[ch_sel]=dac_code, last_ch=ch_sel.
//       Next: en && |ch_mask -> PICK, else IDLE.
//  Latency: PICK entry to result_valid = 1 + WIDTH*(SETTLE+1) cycles (25 with defaults). DONE adds 1 cycle.
//   Back-to-back period is 26 cycles with defaults.
//  en or ch_mask changes mid-conversion never abort it; they take effect at the next IDLE/DONE/PICK decision.
//   Clearing the mask bit of the channel in flight still completes and stores that channel.
//  comp_in is ignored outside COMPARE.
//  ch_sel is stable from PICK through DONE.
//  result/result_ch hold their value until the next DONE.
//  rd_data is a combinational read of store[rd_ch]; a read during the DONE cycle of that channel returns the old value.
// TESTING
//  1. Reset, mask=4'b0001, en=1, model input 0xA5 on ch0 -> result_valid at cycle 26 after reset release;
//     result=0xA5, result_ch=0, rd_data(ch0)=0xA5.
//  2. Model inputs 0x00 and 0xFF -> results 0x00 and 0xFF.
//     Trial code sequence for 0x00 is 80,40,20,10,08,04,02,01.
//  3. mask=4'b1011, en=1 -> result_ch order 0,1,3,0,1,3; no gap beyond DONE->PICK; ch2 never selected.
//  4. Drop en in the SETTLE cycle of bit 3 -> that conversion completes with result_valid, then IDLE, busy=0.
//  5. Assert rst=0 mid-conversion (bit 4), asynchronously between clock edges
//     -> outputs 0 immediately, no result_valid, restart picks ch0.
//  6. mask=0 with en=1 -> stays IDLE, busy=0, dac_code=0;
//     mask=4'b0100 -> ch2 converted repeatedly, ch_sel=2 every conversion.

Source files
------------

// File: rtl/sar_channel_sequencer.sv
// Round-robin successive-approximation sequencer: one comparator and one DAC are shared
// across NCH channels, and the latest conversion of every channel is kept for readback.
module sar_channel_sequencer #(
    parameter int NCH    = 4,
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NCH-1:0]         ch_mask,
    input  logic                   comp_in,
    output logic [$clog2(NCH)-1:0] ch_sel,
    output logic [WIDTH-1:0]       dac_code,
    output logic                   busy,
    output logic [WIDTH-1:0]       result,
    output logic [$clog2(NCH)-1:0] result_ch,
    output logic                   result_valid,
    input  logic [$clog2(NCH)-1:0] rd_ch,
    output logic [WIDTH-1:0]       rd_data
);
    localparam int CW = $clog2(NCH);
    localparam int BW = $clog2(WIDTH);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    ch_sel_q, ch_sel_d;
    logic [CW-1:0]    last_q, last_d;
    logic [CW-1:0]    result_ch_q, result_ch_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             store_we;
    logic [WIDTH-1:0] store_q [NCH];

    // First enabled channel after 'last', wrapping; 'last' itself is the final candidate.
    function automatic logic [CW-1:0] next_pick(input logic [NCH-1:0] mask,
                                                input logic [CW-1:0]  last);
        logic [CW-1:0] pick;
        int            idx;
        pick = last;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(last) + k) % NCH;
            if (mask[idx[CW-1:0]]) pick = CW'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every variable is given its hold value before the case, so no path
        // through the decode leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        ch_sel_d    = ch_sel_q;
        last_d      = last_q;
        dac_d       = dac_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_ch_d = result_ch_q;
        valid_d     = 1'b0;
        store_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                dac_d = '0;
                if (en && |ch_mask) begin
                    state_d  = S_PICK;
                    ch_sel_d = next_pick(ch_mask, last_q);
                end
            end

            S_PICK: begin
                if (|ch_mask) begin
                    state_d            = S_SETTLE;
                    dac_d              = '0;
                    dac_d[WIDTH-1]     = 1'b1;
                    bit_d              = BW'(WIDTH - 1);
                    cnt_d              = SW'(SETTLE - 1);
                end else begin
                    state_d = S_IDLE;
                    dac_d   = '0;
                end
            end

            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_COMPARE;
                else             cnt_d   = cnt_q - 1'b1;
            end

            S_COMPARE: begin
                // Keep the trial bit only if the input is at or above the trial code.
                if (!comp_in) dac_d[bit_q] = 1'b0;
                if (bit_q != '0) begin
                    dac_d[bit_q - 1'b1] = 1'b1;
                    bit_d               = bit_q - 1'b1;
                    cnt_d               = SW'(SETTLE - 1);
                    state_d             = S_SETTLE;
                end else begin
                    state_d     = S_DONE;
                    result_d    = dac_d;
                    result_ch_d = ch_sel_q;
                    valid_d     = 1'b1;
                end
            end

            S_DONE: begin
                // Store is written on the edge leaving DONE, so a same-cycle read sees the old value.
                store_we = 1'b1;
                last_d   = ch_sel_q;
                if (en && |ch_mask) begin
                    state_d  = S_PICK;
                    ch_sel_d = next_pick(ch_mask, ch_sel_q);
                end else begin
                    state_d = S_IDLE;
                    dac_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                dac_d   = '0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values; the result store is reset too, as rd_data must read 0
    // for a channel that has never been converted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ch_sel_q    <= '0;
            last_q      <= CW'(NCH - 1);
            dac_q       <= '0;
            bit_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            valid_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) store_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            ch_sel_q    <= ch_sel_d;
            last_q      <= last_d;
            dac_q       <= dac_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_ch_q <= result_ch_d;
            valid_q     <= valid_d;
            if (store_we) store_q[ch_sel_q] <= dac_q;
        end
    end

    assign ch_sel       = ch_sel_q;
    assign dac_code     = dac_q;
    assign busy         = (state_q != S_IDLE);
    assign result       = result_q;
    assign result_ch    = result_ch_q;
    assign result_valid = valid_q;
    assign rd_data      = store_q[rd_ch];

endmodule

// File: tb/tb_sar_channel_sequencer.sv
// Self-checking bench for sar_channel_sequencer: directed scenarios followed by randomized
// scans, all checked against a transaction-level model of the scheduler and SAR search.
module tb_sar_channel_sequencer;
    localparam int NCH    = 4;
    localparam int WIDTH  = 8;
    localparam int SETTLE = 2;
    localparam int CW     = $clog2(NCH);

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             en      = 1'b0;
    logic [NCH-1:0]   ch_mask = '0;
    logic             comp_in;
    logic [CW-1:0]    ch_sel;
    logic [CW-1:0]    result_ch;
    logic [CW-1:0]    rd_ch   = '0;
    logic [WIDTH-1:0] dac_code;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             result_valid;

    logic [WIDTH-1:0] analog      [NCH];
    logic [WIDTH-1:0] model_store [NCH];
    int               model_last;
    logic [WIDTH-1:0] last_result;
    int               n_tests = 0;
    int               n_fail  = 0;

    sar_channel_sequencer #(
        .NCH   (NCH),
        .WIDTH (WIDTH),
        .SETTLE(SETTLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_mask     (ch_mask),
        .comp_in     (comp_in),
        .ch_sel      (ch_sel),
        .dac_code    (dac_code),
        .busy        (busy),
        .result      (result),
        .result_ch   (result_ch),
        .result_valid(result_valid),
        .rd_ch       (rd_ch),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    // Analog front end: selected channel input compared against the DAC trial code.
    assign comp_in = (analog[ch_sel] >= dac_code);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [NCH-1:0] mask, input int last);
        for (int k = 1; k <= NCH; k++)
            if (mask[(last + k) % NCH]) return (last + k) % NCH;
        return last;
    endfunction

    // Trial code at step j: top j bits already decided from v, next bit set as the trial.
    function automatic logic [WIDTH-1:0] trial_code(input logic [WIDTH-1:0] v, input int step);
        int shift;
        int hi;
        shift = WIDTH - step;
        hi    = (int'(v) >> shift) << shift;
        return WIDTH'(hi | (1 << (WIDTH - 1 - step)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) model_store[i] = '0;
        model_last  = NCH - 1;
        last_result = '0;
    endtask

    // Called at the sampling point of the PICK cycle; returns at the DONE cycle.
    task automatic watch_conv(input int exp_ch, input int poke_at,
                              input logic poke_en, input logic [NCH-1:0] poke_mask);
        logic [WIDTH-1:0] v;
        int               idx;
        v = analog[exp_ch];
        check("pick_busy", 32'(busy), 32'(1));
        check("pick_ch_sel", 32'(ch_sel), exp_ch);
        check("rd_data", 32'(rd_data), 32'(model_store[rd_ch]));
        for (int j = 0; j < WIDTH; j++) begin
            for (int s = 0; s <= SETTLE; s++) begin
                @(negedge clk);
                idx = 1 + j * (SETTLE + 1) + s;
                check("trial_code", 32'(dac_code), 32'(trial_code(v, j)));
                if (s == SETTLE) check("ch_sel_hold", 32'(ch_sel), exp_ch);
                if (idx == poke_at) begin
                    en      = poke_en;
                    ch_mask = poke_mask;
                end
            end
        end
        check("valid_early", 32'(result_valid), 32'(0));
        @(negedge clk);
        check("done_valid", 32'(result_valid), 32'(1));
        check("done_result", 32'(result), 32'(v));
        check("done_result_ch", 32'(result_ch), exp_ch);
        check("done_rd_old", 32'(rd_data), 32'(model_store[rd_ch]));
        model_store[exp_ch] = v;
        model_last          = exp_ch;
        last_result         = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [6];
        int exp_ch;
        order = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < NCH; i++) analog[i] = '0;
        model_reset();

        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_dac", 32'(dac_code), 32'(0));
        check("rst_ch_sel", 32'(ch_sel), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_result_ch", 32'(result_ch), 32'(0));
        check("rst_valid", 32'(result_valid), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));

        // Single channel, mid-scale value, then both extremes.
        analog[0] = 8'hA5;
        en        = 1'b1;
        ch_mask   = 4'b0001;
        rd_ch     = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        watch_conv(0, -1, 1'b0, '0);
        analog[0] = 8'h00;
        @(negedge clk);
        watch_conv(0, -1, 1'b0, '0);
        analog[0] = 8'hFF;
        @(negedge clk);
        watch_conv(0, -1, 1'b0, '0);

        // Sparse mask from reset: fixed round-robin order, back to back.
        ch_mask = 4'b1011;
        rd_ch   = CW'(1);
        for (int i = 0; i < NCH; i++) analog[i] = WIDTH'($urandom_range(0, 255));
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            watch_conv(order[i], -1, 1'b0, '0);
            @(negedge clk);
        end

        // Drop en and clear the in-flight channel's mask bit during the bit-3 settle.
        watch_conv(0, 1 + 4 * (SETTLE + 1), 1'b0, 4'b1010);
        rd_ch = '0;
        repeat (4) begin
            @(negedge clk);
            check("stop_busy", 32'(busy), 32'(0));
            check("stop_valid", 32'(result_valid), 32'(0));
            check("stop_dac", 32'(dac_code), 32'(0));
            check("stop_result_hold", 32'(result), 32'(last_result));
        end
        check("stop_rd_ch0", 32'(rd_data), 32'(model_store[0]));

        // Asynchronous reset in the middle of bit 4.
        for (int i = 0; i < NCH; i++) analog[i] = WIDTH'($urandom_range(0, 255));
        ch_mask = 4'b0101;
        en      = 1'b1;
        @(negedge clk);
        check("abort_pick_ch", 32'(ch_sel), 32'(model_pick(ch_mask, model_last)));
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_dac", 32'(dac_code), 32'(0));
        check("abort_ch_sel", 32'(ch_sel), 32'(0));
        check("abort_result", 32'(result), 32'(0));
        check("abort_result_ch", 32'(result_ch), 32'(0));
        check("abort_valid", 32'(result_valid), 32'(0));
        check("abort_rd_data", 32'(rd_data), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        watch_conv(0, -1, 1'b0, '0);

        // Empty mask keeps the sequencer idle; a single-bit mask reselects the same channel.
        ch_mask = '0;
        repeat (8) begin
            @(negedge clk);
            check("empty_busy", 32'(busy), 32'(0));
            check("empty_dac", 32'(dac_code), 32'(0));
        end
        ch_mask = 4'b0100;
        rd_ch   = CW'(2);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            watch_conv(2, -1, 1'b0, '0);
            if (i < 2) @(negedge clk);
        end

        // Randomized scans with mid-conversion disturbances of en/ch_mask.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NCH; i++) analog[i] = WIDTH'($urandom_range(0, 255));
            ch_mask = ($urandom_range(0, 6) == 0) ? '0 : NCH'($urandom_range(1, (1 << NCH) - 1));
            en      = ($urandom_range(0, 7) != 0);
            rd_ch   = CW'($urandom_range(0, NCH - 1));
            if (!(en && |ch_mask)) begin
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    check("rand_idle_busy", 32'(busy), 32'(0));
                end
                en      = 1'b1;
                ch_mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            end
            exp_ch = model_pick(ch_mask, model_last);
            @(negedge clk);
            watch_conv(exp_ch, $urandom_range(1, WIDTH * (SETTLE + 1)),
                       1'($urandom_range(0, 1)), NCH'($urandom_range(0, (1 << NCH) - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
